// File: rtl/matrix_key_entry_if.sv
// Keypad/entry signal bundle for matrix_key_entry.
//   key_col   : keypad columns, active-low, asynchronous (driven by the keypad)
//   key_row   : row strobes, one-hot active-low
//   key_pulse : one-cycle strobe per accepted press
//   key_code  : code of the last accepted key
//   edit_val  : value currently being typed
//   digit_cnt : digits in edit_val (0..5)
//   num_out   : last committed value
//   num_valid : one-cycle strobe when num_out updates
// master = the scanner/entry block, slave = keypad plus value consumer.
interface matrix_key_entry_if;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic [15:0] edit_val;
  logic [2:0]  digit_cnt;
  logic [15:0] num_out;
  logic        num_valid;

  modport master (
    input  key_col,
    output key_row, key_pulse, key_code, edit_val, digit_cnt, num_out, num_valid
  );

  modport slave (
    output key_col,
    input  key_row, key_pulse, key_code, edit_val, digit_cnt, num_out, num_valid
  );
endinterface

// File: rtl/matrix_key_entry.sv
// 4x4 matrix keypad scanner with debounce and decimal entry.
// Rows are strobed active-low for SCAN_DIV clocks each; a full four-row frame
// yields one key code (or none / ghosted). A two-state debouncer needs
// DEB_FRAMES identical frames to accept a press or a release. Digits build a
// 16-bit value (max 5 digits, no wrap), A=ENTER, B=BACKSPACE, C=CLEAR.
// Ports:
//   sys_clk : system clock
//   sys_rst : synchronous active-high reset
//   kif     : matrix_key_entry_if.master (key_col in, all results out)
// Optional: define KEY_LIMIT_EN to clamp the committed value to MAX_VAL.
module matrix_key_entry #(
  parameter int unsigned SCAN_DIV   = 50_000,
  parameter int unsigned DEB_FRAMES = 4
`ifdef KEY_LIMIT_EN
  ,
  parameter logic [15:0] MAX_VAL    = 16'd65535
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  matrix_key_entry_if.master kif
);

  localparam int unsigned   CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned   DW         = $clog2(DEB_FRAMES + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEB_FRAMES);

  typedef enum logic {
    S_RELEASED,
    S_PRESSED
  } deb_state_e;

  // Column synchroniser and scan
  logic [3:0]    col_meta_q, col_sync_q;
  logic [CW-1:0] scan_cnt_q;
  logic [3:0]    row_q;
  logic [1:0]    row_idx_q;
  // Frame accumulation: saturating key count (0,1,2+) and first key code
  logic [1:0]    acc_hits_q;
  logic [3:0]    acc_code_q;
  // Debounce
  deb_state_e    state_q;
  logic [DW-1:0] deb_cnt_q;
  logic          prev_hit_q;
  logic [3:0]    prev_code_q;
  // Outputs / entry
  logic          key_pulse_q;
  logic [3:0]    key_code_q;
  logic [15:0]   edit_val_q;
  logic [2:0]    digit_cnt_q;
  logic [15:0]   num_out_q;
  logic          num_valid_q;

  // Combinational helpers
  logic          scan_tick, frame_end, frame_hit, same_frame;
  logic [1:0]    row_hits, row_col, base_hits, hits_d;
  logic [2:0]    hit_sum;
  logic [3:0]    code_d;
  logic [DW-1:0] deb_inc, press_cnt;
  logic [16:0]   digit_prod;
  logic          digit_ok;
  logic [15:0]   commit_val;

  assign scan_tick = (scan_cnt_q == SCAN_LAST);
  assign frame_end = scan_tick && (row_idx_q == 2'd3);

  always_comb begin
    row_hits = '0;
    row_col  = '0;
    // Walk columns high to low so row_col ends on the lowest low column.
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col_sync_q[3 - i]) begin
        row_col = 2'(3 - i);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
    base_hits = (row_idx_q == 2'd0) ? 2'd0 : acc_hits_q;
    hit_sum   = {1'b0, base_hits} + {1'b0, row_hits};
    hits_d    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_d    = (base_hits == 2'd0 && row_hits != 2'd0) ? {row_idx_q, row_col} : acc_code_q;
  end

  assign frame_hit  = (hits_d == 2'd1);
  assign same_frame = prev_hit_q && (prev_code_q == code_d);
  assign deb_inc    = deb_cnt_q + 1'b1;
  assign press_cnt  = same_frame ? deb_inc : DW'(1);

  // With fewer than five digits edit_val <= 9999, so 17 bits cannot overflow.
  assign digit_prod = 17'(edit_val_q) * 17'd10 + 17'(key_code_q);
  assign digit_ok   = (digit_cnt_q < 3'd5) && (digit_prod <= 17'd65535);

`ifdef KEY_LIMIT_EN
  assign commit_val = (edit_val_q > MAX_VAL) ? MAX_VAL : edit_val_q;
`else
  assign commit_val = edit_val_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col_meta_q  <= '1;
      col_sync_q  <= '1;
      scan_cnt_q  <= '0;
      row_q       <= 4'b1110;
      row_idx_q   <= '0;
      acc_hits_q  <= '0;
      acc_code_q  <= '0;
      state_q     <= S_RELEASED;
      deb_cnt_q   <= '0;
      prev_hit_q  <= 1'b0;
      prev_code_q <= '0;
      key_pulse_q <= 1'b0;
      key_code_q  <= '0;
      edit_val_q  <= '0;
      digit_cnt_q <= '0;
      num_out_q   <= '0;
      num_valid_q <= 1'b0;
    end else begin
      col_meta_q  <= kif.key_col;
      col_sync_q  <= col_meta_q;
      key_pulse_q <= 1'b0;
      num_valid_q <= 1'b0;

      if (scan_tick) begin
        scan_cnt_q <= '0;
        row_q      <= {row_q[2:0], row_q[3]};
        row_idx_q  <= row_idx_q + 2'd1;
        acc_hits_q <= hits_d;
        acc_code_q <= code_d;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end

      if (frame_end) begin
        prev_hit_q  <= frame_hit;
        prev_code_q <= code_d;
        case (state_q)
          S_RELEASED: begin
            if (!frame_hit) begin
              deb_cnt_q <= '0;
            end else if (press_cnt >= DEB_TARGET) begin
              state_q     <= S_PRESSED;
              deb_cnt_q   <= '0;
              key_code_q  <= code_d;
              key_pulse_q <= 1'b1;
            end else begin
              deb_cnt_q <= press_cnt;
            end
          end
          S_PRESSED: begin
            if (frame_hit) begin
              deb_cnt_q <= '0;
            end else if (deb_inc >= DEB_TARGET) begin
              state_q   <= S_RELEASED;
              deb_cnt_q <= '0;
            end else begin
              deb_cnt_q <= deb_inc;
            end
          end
          default: begin
            state_q   <= S_RELEASED;
            deb_cnt_q <= '0;
          end
        endcase
      end

      if (key_pulse_q) begin
        case (key_code_q)
          4'hA: begin
            if (digit_cnt_q != 3'd0) begin
              num_out_q   <= commit_val;
              num_valid_q <= 1'b1;
              edit_val_q  <= '0;
              digit_cnt_q <= '0;
            end
          end
          4'hB: begin
            edit_val_q <= edit_val_q / 16'd10;
            if (digit_cnt_q != 3'd0) digit_cnt_q <= digit_cnt_q - 3'd1;
          end
          4'hC: begin
            edit_val_q  <= '0;
            digit_cnt_q <= '0;
          end
          4'hD, 4'hE, 4'hF: ;
          default: begin
            if (digit_ok) begin
              edit_val_q  <= digit_prod[15:0];
              digit_cnt_q <= digit_cnt_q + 3'd1;
            end
          end
        endcase
      end
    end
  end

  assign kif.key_row   = row_q;
  assign kif.key_pulse = key_pulse_q;
  assign kif.key_code  = key_code_q;
  assign kif.edit_val  = edit_val_q;
  assign kif.digit_cnt = digit_cnt_q;
  assign kif.num_out   = num_out_q;
  assign kif.num_valid = num_valid_q;

endmodule
